memwb: RTL and testbench
========================

Name: memwb

Overview:
- Memory-access stage and MEM/WB pipeline register, sitting directly downstream of the EX/MEM register.
- Consumes the EX/MEM outputs (ALU result/address, store data, rd, GPRWr/DMWr/MTR, lw).
- Performs loads and stores against an external data memory over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding.
- Presents registered writeback values to the register file and to the forwarding/hazard logic.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles without i_dm_ack before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_busC  in  32  ALU result; data memory byte address for loads/stores
- i_busB  in  32  store data
- i_rd  in  5  destination register
- i_GPRWR  in  1  register-file write enable
- i_DMWR  in  1  data-memory write (store)
- i_MTR  in  1  memory-to-register (load)
- i_lw  in  1  load-word marker, passed through for hazard logic
- o_dm_req  out  1  memory request, registered
- o_dm_we  out  1  1 = write, 0 = read; valid while o_dm_req
- o_dm_addr  out  32  word address: latched i_busC with [1:0] forced to 00
- o_dm_wdata  out  32  latched i_busB
- i_dm_ack  in  1  memory completion, single-cycle pulse
- i_dm_rdata  in  32  read data; valid when i_dm_ack
- o_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- o_wdata  out  32  writeback data
- o_rd  out  5  writeback register
- o_GPRWR  out  1  writeback enable
- o_lw  out  1  registered lw marker
- o_err  out  1  sticky error: timeout or misaligned access

Behaviour:
- Reset (rst=1 at a rising edge):
  - state IDLE, counter 0.
  - o_dm_req, o_dm_we, o_GPRWR, o_lw, o_err cleared.
  - o_dm_addr, o_dm_wdata, o_wdata cleared; o_rd = 0.
  - A reset during BUSY drops o_dm_req in the next cycle and discards the access; any late ack is ignored.
- Access detection: access = i_DMWR | i_MTR. If both are set, it is treated as a read.
- FSM IDLE:
  - No access: the WB register loads o_wdata=i_busC, o_rd=i_rd, o_GPRWR=i_GPRWR & (i_rd!=0), o_lw=i_lw. Latency is 1 cycle.
  - Access:
    - Latch the request into the address/data outputs: o_dm_addr={i_busC[31:2],2'b00}, o_dm_wdata=i_busB, o_dm_we=i_DMWR & ~i_MTR.
    - Latch rd, GPRWR, MTR and lw internally.
    - Set o_dm_req=1, counter=0, go to BUSY.
    - WB register loads a bubble (o_GPRWR=0, o_lw=0).
    - If i_busC[1:0]!=0, set o_err; the access still proceeds to the aligned address.
- FSM BUSY:
  - o_dm_req stays 1. The WB register loads a bubble every cycle without ack.
  - On i_dm_ack:
    - o_dm_req cleared, go to IDLE.
    - WB register loads: o_wdata = MTR ? i_dm_rdata : latched busC; o_rd = latched rd; o_GPRWR = latched GPRWR & (rd!=0); o_lw = latched lw.
  - Otherwise the counter increments. When counter reaches TIMEOUT-1 without ack: o_dm_req cleared, o_err set, WB bubble, go to IDLE. The instruction is dropped.
- o_stall (combinational):
  - Asserted when (IDLE & access & ~rst) | (BUSY & ~i_dm_ack & not timing out this cycle).
  - Upstream therefore holds the memory instruction until the completing edge, then advances on that same edge.
- Cycle counts: minimum memory-op latency is 2 cycles (ack in the first BUSY cycle); an ack at the Nth BUSY cycle gives N+1 cycles.
- i_dm_ack while IDLE is ignored.
- o_err is sticky and cleared only by rst.
- Back-to-back accesses:
  - After completion the FSM is IDLE on the next cycle. If that instruction also accesses memory, a new request issues immediately.
  - o_dm_req is low for at least 1 cycle between requests.

Test Plan:
- ALU op, i_busC=0x1234, rd=5, GPRWR=1, no access → next cycle o_wdata=0x1234, o_rd=5, o_GPRWR=1, o_stall=0 throughout.
- Load, i_busC=0x40, rd=8, MTR=1, ack 3 cycles after req with rdata=0xDEADBEEF → o_dm_addr=0x40, o_dm_we=0, o_stall high for 3 cycles, then o_wdata=0xDEADBEEF, o_rd=8, o_GPRWR=1, o_lw passed through.
- Store, i_busC=0x42, busB=0xA5A5A5A5, ack immediately → o_dm_addr=0x40, o_dm_we=1, o_dm_wdata=0xA5A5A5A5, o_err=1, o_GPRWR=0, stall 1 cycle.
- Load with no ack, TIMEOUT=16 → o_dm_req drops after 16 BUSY cycles, o_err=1, o_stall deasserts, no writeback; a later ack is ignored.
- Write to rd=0 with GPRWR=1 → o_GPRWR=0.
- rst asserted in 2nd BUSY cycle → next cycle o_dm_req=0, state IDLE, o_stall=0, all outputs 0.

Source files
------------

// File: rtl/memwb.sv
// Memory-access stage and MEM/WB pipeline register: issues data-memory
// requests over a req/ack handshake, stalls upstream while busy, registers writeback.
module memwb #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_busC,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_rd,
  input  logic        i_GPRWR,
  input  logic        i_DMWR,
  input  logic        i_MTR,
  input  logic        i_lw,
  output logic        o_dm_req,
  output logic        o_dm_we,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic        i_dm_ack,
  input  logic [31:0] i_dm_rdata,
  output logic        o_stall,
  output logic [31:0] o_wdata,
  output logic [4:0]  o_rd,
  output logic        o_GPRWR,
  output logic        o_lw,
  output logic        o_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] busc_p1;
  logic [4:0]  rd_p1;
  logic        gprwr_p1;
  logic        mtr_p1;
  logic        lw_p1;

  logic access;
  logic timeout_hit;

  // Register r0 is hardwired to zero, so a write to it is never enabled.
  function automatic logic wb_en(input logic gprwr, input logic [4:0] rd);
    return gprwr & (rd != 5'd0);
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign access      = i_DMWR | i_MTR;
  assign timeout_hit = (state == BUSY) & ~i_dm_ack & (cnt == CNT_LAST);
  assign o_stall     = ((state == IDLE) & access & ~rst) |
                       ((state == BUSY) & ~i_dm_ack & ~timeout_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      o_dm_req   <= 1'b0;
      o_dm_we    <= 1'b0;
      o_dm_addr  <= 32'd0;
      o_dm_wdata <= 32'd0;
      o_wdata    <= 32'd0;
      o_rd       <= 5'd0;
      o_GPRWR    <= 1'b0;
      o_lw       <= 1'b0;
      o_err      <= 1'b0;
      busc_p1    <= 32'd0;
      rd_p1      <= 5'd0;
      gprwr_p1   <= 1'b0;
      mtr_p1     <= 1'b0;
      lw_p1      <= 1'b0;
    end else if (state == IDLE) begin
      if (access) begin
        // Load wins when both DMWR and MTR are set; misalignment is flagged but the aligned access proceeds.
        o_dm_addr  <= word_addr(i_busC);
        o_dm_wdata <= i_busB;
        o_dm_we    <= i_DMWR & ~i_MTR;
        o_dm_req   <= 1'b1;
        busc_p1    <= i_busC;
        rd_p1      <= i_rd;
        gprwr_p1   <= i_GPRWR;
        mtr_p1     <= i_MTR;
        lw_p1      <= i_lw;
        cnt        <= 8'd0;
        state      <= BUSY;
        o_GPRWR    <= 1'b0;
        o_lw       <= 1'b0;
        if (i_busC[1:0] != 2'b00) o_err <= 1'b1;
      end else begin
        o_wdata <= i_busC;
        o_rd    <= i_rd;
        o_GPRWR <= wb_en(i_GPRWR, i_rd);
        o_lw    <= i_lw;
      end
    end else begin
      if (i_dm_ack) begin
        o_dm_req <= 1'b0;
        state    <= IDLE;
        o_wdata  <= mtr_p1 ? i_dm_rdata : busc_p1;
        o_rd     <= rd_p1;
        o_GPRWR  <= wb_en(gprwr_p1, rd_p1);
        o_lw     <= lw_p1;
      end else begin
        o_GPRWR <= 1'b0;
        o_lw    <= 1'b0;
        if (timeout_hit) begin
          o_dm_req <= 1'b0;
          o_err    <= 1'b1;
          state    <= IDLE;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memwb.sv
// Bench for memwb: directed cases plus randomized instruction stream,
// checked against a transaction-level model of each instruction's outcome.
module tb_memwb;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_busC, i_busB, i_dm_rdata;
  logic [4:0]  i_rd;
  logic        i_GPRWR, i_DMWR, i_MTR, i_lw, i_dm_ack;
  logic        o_dm_req, o_dm_we, o_stall, o_GPRWR, o_lw, o_err;
  logic [31:0] o_dm_addr, o_dm_wdata, o_wdata;
  logic [4:0]  o_rd;

  always #5 clk = ~clk;

  memwb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_busC(i_busC), .i_busB(i_busB), .i_rd(i_rd),
    .i_GPRWR(i_GPRWR), .i_DMWR(i_DMWR), .i_MTR(i_MTR), .i_lw(i_lw),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
    .o_dm_wdata(o_dm_wdata), .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_stall(o_stall), .o_wdata(o_wdata), .o_rd(o_rd), .o_GPRWR(o_GPRWR),
    .o_lw(o_lw), .o_err(o_err)
  );

  int   total = 0;
  int   bad = 0;
  logic err_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(o_dm_req), 0);
    check({tag, "_we"}, 32'(o_dm_we), 0);
    check({tag, "_addr"}, o_dm_addr, 0);
    check({tag, "_dwdata"}, o_dm_wdata, 0);
    check({tag, "_wdata"}, o_wdata, 0);
    check({tag, "_rd"}, 32'(o_rd), 0);
    check({tag, "_gpr"}, 32'(o_GPRWR), 0);
    check({tag, "_lw"}, 32'(o_lw), 0);
    check({tag, "_err"}, 32'(o_err), 0);
    check({tag, "_stall"}, 32'(o_stall), 0);
  endtask

  task automatic set_nop;
    i_busC = 0; i_busB = 0; i_rd = 0; i_GPRWR = 0; i_DMWR = 0; i_MTR = 0; i_lw = 0;
    i_dm_ack = 0; i_dm_rdata = 0;
  endtask

  // Non-memory instruction: writeback one cycle later, never stalls; a stray ack is ignored.
  task automatic do_nop(input logic [31:0] c, input logic [4:0] rd, input logic g,
                        input logic lw, input logic ack);
    i_busC = c; i_busB = $urandom; i_rd = rd; i_GPRWR = g; i_DMWR = 0; i_MTR = 0;
    i_lw = lw; i_dm_ack = ack; i_dm_rdata = $urandom;
    #1;
    check("nop_stall", 32'(o_stall), 0);
    step;
    i_dm_ack = 0;
    check("nop_wdata", o_wdata, c);
    check("nop_rd", 32'(o_rd), 32'(rd));
    check("nop_gpr", 32'(o_GPRWR), 32'(g && rd != 0));
    check("nop_lw", 32'(o_lw), 32'(lw));
    check("nop_req", 32'(o_dm_req), 0);
    check("nop_err", 32'(o_err), 32'(err_m));
  endtask

  // Memory instruction: ack arrives in BUSY cycle d (d > TO means never);
  // rstk > 0 asserts reset in BUSY cycle rstk instead.
  task automatic do_mem(input logic [31:0] c, input logic [31:0] b, input logic [4:0] rd,
                        input logic g, input logic wr, input logic mtr, input logic lw,
                        input int d, input logic [31:0] rdata, input int rstk);
    i_busC = c; i_busB = b; i_rd = rd; i_GPRWR = g; i_DMWR = wr; i_MTR = mtr;
    i_lw = lw; i_dm_ack = 0; i_dm_rdata = 0;
    #1;
    check("mem_stall_idle", 32'(o_stall), 1);
    step;
    if (c[1:0] != 2'b00) err_m = 1'b1;
    check("mem_req", 32'(o_dm_req), 1);
    check("mem_addr", o_dm_addr, {c[31:2], 2'b00});
    check("mem_we", 32'(o_dm_we), 32'(wr && !mtr));
    check("mem_dwdata", o_dm_wdata, b);
    check("mem_bubble_gpr", 32'(o_GPRWR), 0);
    check("mem_bubble_lw", 32'(o_lw), 0);
    check("mem_err", 32'(o_err), 32'(err_m));
    for (int k = 1; k <= TO; k++) begin
      if (rstk == k) begin
        rst = 1;
        step;
        rst = 0;
        set_nop;
        err_m = 1'b0;
        #1;
        check_all_zero("rst_busy");
        return;
      end
      if (k == d) begin
        i_dm_ack = 1; i_dm_rdata = rdata;
        #1;
        check("ack_stall", 32'(o_stall), 0);
        step;
        i_dm_ack = 0;
        check("ack_req", 32'(o_dm_req), 0);
        check("ack_wdata", o_wdata, mtr ? rdata : c);
        check("ack_rd", 32'(o_rd), 32'(rd));
        check("ack_gpr", 32'(o_GPRWR), 32'(g && rd != 0));
        check("ack_lw", 32'(o_lw), 32'(lw));
        check("ack_err", 32'(o_err), 32'(err_m));
        return;
      end
      if (k == TO) begin
        #1;
        check("to_stall", 32'(o_stall), 0);
        step;
        err_m = 1'b1;
        check("to_req", 32'(o_dm_req), 0);
        check("to_err", 32'(o_err), 1);
        check("to_gpr", 32'(o_GPRWR), 0);
        return;
      end
      #1;
      check("busy_stall", 32'(o_stall), 1);
      step;
      check("busy_req", 32'(o_dm_req), 1);
      check("busy_gpr", 32'(o_GPRWR), 0);
    end
  endtask

  initial begin
    set_nop;
    i_MTR = 1;
    rst = 1;
    step;
    step;
    #1;
    check_all_zero("reset");
    rst = 0;
    set_nop;

    do_nop(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0);
    do_mem(32'h40, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF, 0);
    do_mem(32'h42, 32'hA5A5A5A5, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0, 0);
    do_mem(32'h80, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, TO + 5, 32'h0, 0);
    do_nop(32'h55, 5'd4, 1'b1, 1'b1, 1'b1);
    do_nop(32'h77, 5'd0, 1'b1, 1'b0, 1'b0);
    do_mem(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, TO + 1, 32'h0, 2);
    do_nop(32'h99, 5'd6, 1'b1, 1'b0, 1'b1);
    do_mem(32'h200, 32'h1111, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2, 32'hCAFEF00D, 0);

    for (int n = 0; n < 400; n++) begin
      int          sel;
      logic [31:0] c;
      logic [4:0]  rd;
      sel = int'($urandom_range(0, 19));
      c   = $urandom;
      if ($urandom_range(0, 7) != 0) c[1:0] = 2'b00;
      rd  = 5'($urandom_range(0, 31));
      if (sel < 10) begin
        do_nop(c, rd, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end else if (sel < 18) begin
        logic wr, mtr;
        wr  = 1'($urandom);
        mtr = ~wr | 1'($urandom);
        do_mem(c, $urandom, rd, 1'($urandom), wr, mtr, 1'($urandom),
               int'($urandom_range(1, TO + 2)), $urandom, 0);
      end else begin
        do_mem(c, $urandom, rd, 1'($urandom), 1'b0, 1'b1, 1'($urandom),
               TO + 1, $urandom, int'($urandom_range(1, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
